// File: rtl/branch_resolve_unit_if.sv
// Handshake and data bundle between EX, the branch resolve stage and the redirect logic.
// The slave modport is the resolve unit's view; master is the surrounding pipeline's view.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [3:0]        br_op;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] offset;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  mp_count;

  modport slave (
    input  in_valid, operand_a, operand_b, br_op, pc, offset, pred_taken, pred_target,
           flush, out_ready,
    output in_ready, out_valid, taken, target, mispredict, redirect_pc, br_count, mp_count
  );

  modport master (
    output in_valid, operand_a, operand_b, br_op, pc, offset, pred_taken, pred_target,
           flush, out_ready,
    input  in_ready, out_valid, taken, target, mispredict, redirect_pc, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered LoongArch branch resolution: evaluates condition and target, checks the
// front-end prediction, and presents a one-cycle-latency redirect with statistics counters.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input logic                 clk,
  input logic                 reset,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              xfer;
  logic              cond;
  logic [ADDR_W-1:0] calc_target;
  logic [ADDR_W-1:0] fallthrough;
  logic              calc_mp;
  logic [ADDR_W-1:0] calc_redirect;

  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              res_mp;
  logic [ADDR_W-1:0] res_redirect;
  logic              res_is_branch;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mp_cnt;

  assign bus.in_ready = ~reset & ~bus.flush & ((state == EMPTY) | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  // A flushed result is killed, so it never counts as delivered.
  assign xfer         = (state == FULL) & bus.out_ready & ~bus.flush;

  // Result register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: flush beats accept, accept beats a plain transfer.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = EMPTY;
    end else if (accept) begin
      state_next = FULL;
    end else if (xfer) begin
      state_next = EMPTY;
    end else begin
      state_next = state;
    end
  end

  // Branch condition, target and prediction check.
  always_comb begin
    cond = 1'b0;
    case (bus.br_op)
      4'b0000: cond = (bus.operand_a == bus.operand_b);
      4'b0001: cond = (bus.operand_a != bus.operand_b);
      4'b0010: cond = ($signed(bus.operand_a) <  $signed(bus.operand_b));
      4'b0011: cond = ($signed(bus.operand_a) >= $signed(bus.operand_b));
      4'b0100: cond = (bus.operand_a <  bus.operand_b);
      4'b0101: cond = (bus.operand_a >= bus.operand_b);
      4'b0110: cond = 1'b1;
      4'b0111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
    if (bus.br_op == 4'b0111) begin
      calc_target = bus.operand_a[ADDR_W-1:0] + bus.offset;
    end else begin
      calc_target = bus.pc + bus.offset;
    end
    fallthrough   = bus.pc + ADDR_W'(4);
    calc_mp       = (cond != bus.pred_taken) |
                    (cond & bus.pred_taken & (calc_target != bus.pred_target));
    calc_redirect = cond ? calc_target : fallthrough;
  end

  // Result capture on accept; held otherwise so a stalled result stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_taken     <= 1'b0;
      res_target    <= '0;
      res_mp        <= 1'b0;
      res_redirect  <= '0;
      res_is_branch <= 1'b0;
    end else if (accept) begin
      res_taken     <= cond;
      res_target    <= calc_target;
      res_mp        <= calc_mp;
      res_redirect  <= calc_redirect;
      res_is_branch <= ~bus.br_op[3];
    end else begin
      res_taken     <= res_taken;
      res_target    <= res_target;
      res_mp        <= res_mp;
      res_redirect  <= res_redirect;
      res_is_branch <= res_is_branch;
    end
  end

  // Saturating statistics, advanced only when a result is delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (xfer) begin
      if (res_is_branch && (br_cnt != {CNT_W{1'b1}})) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end else begin
        br_cnt <= br_cnt;
      end
      if (res_mp && (mp_cnt != {CNT_W{1'b1}})) begin
        mp_cnt <= mp_cnt + CNT_W'(1);
      end else begin
        mp_cnt <= mp_cnt;
      end
    end else begin
      br_cnt <= br_cnt;
      mp_cnt <= mp_cnt;
    end
  end

  assign bus.out_valid   = (state == FULL);
  assign bus.taken       = res_taken;
  assign bus.target      = res_target;
  assign bus.mispredict  = res_mp;
  assign bus.redirect_pc = res_redirect;
  assign bus.br_count    = br_cnt;
  assign bus.mp_count    = mp_cnt;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, parametrised branch resolution stage placed between EX and the fetch redirect logic.
- Evaluates the full LoongArch conditional and unconditional branch set: signed/unsigned compares, PC-relative and register-indirect targets.
- Checks the outcome against the front-end prediction and produces a one-cycle-latency redirect with a valid/ready handshake.
- Keeps saturating statistics counters for resolved branches and mispredicts.

Parameters:
- DATA_W, 32, operand width for compares.
- ADDR_W, 32, PC/target width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  EX presents a branch-class instruction.
- in_ready  output  1  unit can accept this cycle.
- operand_a  input  DATA_W  rj value.
- operand_b  input  DATA_W  rd value.
- br_op  input  4  operation code; see Behaviour.
- pc  input  ADDR_W  PC of the instruction.
- offset  input  ADDR_W  sign-extended, pre-shifted byte offset.
- pred_taken  input  1  front-end predicted taken.
- pred_target  input  ADDR_W  front-end predicted target.
- flush  input  1  kill the in-flight result.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes the result.
- taken  output  1  resolved direction.
- target  output  ADDR_W  computed taken target.
- mispredict  output  1  prediction was wrong.
- redirect_pc  output  ADDR_W  correct next PC.
- br_count  output  CNT_W  resolved-branch counter.
- mp_count  output  CNT_W  mispredict counter.

Behaviour:
- br_op encoding, conditions on the full DATA_W width:
  - 0000 BEQ: a==b.
  - 0001 BNE: a!=b.
  - 0010 BLT: signed a<b.
  - 0011 BGE: signed a>=b.
  - 0100 BLTU: unsigned a<b.
  - 0101 BGEU: unsigned a>=b.
  - 0110 B/BL: always taken.
  - 0111 JIRL: always taken.
  - 1xxx: non-branch; taken=0.
- Target computation, modulo 2^ADDR_W (wrap-around, no overflow flag):
  - PC-relative (0000–0110): target = pc + offset.
  - JIRL: target = operand_a[ADDR_W-1:0] + offset.
  - Fallthrough = pc + 4.
- Mispredict rule: mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
- Redirect: redirect_pc = taken ? target : pc+4.
- Handshake:
  - in_ready = ~flush & (~out_valid | out_ready).
  - Accept occurs when in_valid & in_ready.
  - On accept, all outputs are registered and out_valid=1 the next cycle (latency 1).
  - Back-to-back accepts are allowed when out_ready=1, giving full throughput.
  - While out_valid & ~out_ready, all result outputs hold stable and in_ready=0.
  - Transfer occurs when out_valid & out_ready; out_valid drops next cycle unless a new accept occurs.
- Flush:
  - When flush=1, next cycle out_valid=0.
  - Any input in that cycle is not accepted (in_ready=0).
  - Flush has priority over accept and over hold.
- Counters:
  - Update on transfer only, never on accept or flush.
  - br_count increments for br_op[3]==0.
  - mp_count increments when mispredict=1; non-branches predicted taken count as mispredicts.
  - Both counters saturate at all-ones.
- Reset:
  - Sets out_valid=0, taken=0, mispredict=0, target=0, redirect_pc=0, br_count=0, mp_count=0.
  - in_ready=0 during the reset cycle.
  - A result pending when reset is asserted is discarded and not counted.
- State: a two-state result register, EMPTY↔FULL.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on transfer without accept, on flush, or on reset.
  - FULL→FULL on transfer with simultaneous accept.

Test Plan:
- Signed vs unsigned: BLT a=0xFFFFFFFF, b=1 → taken=1. BLTU with the same operands → taken=0. BGEU → taken=1. Each result arrives exactly 1 cycle after accept.
- Target wrap: BEQ a=b, pc=0xFFFFFFF8, offset=0x10 → target=0x00000008, redirect_pc=0x8. BNE with the same inputs → redirect_pc=0xFFFFFFFC.
- Mispredict: JIRL a=0x1000, offset=0x20, pred_taken=1, pred_target=0x1024 → target=0x1020, mispredict=1, mp_count +1 on transfer. Non-branch br_op=1000 with pred_taken=1 → mispredict=1, br_count unchanged.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable throughout. Then out_ready=1 → transfer and new accept in the same cycle; br_count advances by exactly 1.
- Flush: accept a BNE, assert flush the next cycle with out_ready=0 → out_valid=0 the following cycle, counters unchanged. The flush-cycle input is not accepted.
- Reset and saturation: preload counters near max via CNT_W=4 → 16 mispredicting transfers leave mp_count=0xF. Reset mid-stall → all outputs zero the next cycle.
